// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//
// Display timing generator for the Rojobot world video controller. Runs on the
// 25 MHz pixel clock and produces the scan addresses used by the icon and
// world-map pixel sources, together with sync and visible-region strobes.
// Defaults give 640x480 @ 60 Hz.
//
// The sync and video_on strobes are delayed by PIPE_DELAY register stages so
// they line up with pixel sources that register their outputs. The scan
// addresses and the end-of-line / end-of-frame pulses are not delayed.
//
// Ports:
//   clock         in   pixel clock
//   rst           in   synchronous, active-high reset
//   Pixel_column  out  horizontal counter, 0..H_TOTAL-1
//   Pixel_row     out  vertical counter, 0..V_TOTAL-1
//   horiz_sync    out  horizontal sync, delayed by PIPE_DELAY
//   vert_sync     out  vertical sync, delayed by PIPE_DELAY
//   video_on      out  visible-region flag, delayed by PIPE_DELAY
//   end_of_line   out  high while the column counter is at H_TOTAL-1
//   end_of_frame  out  high while both counters are at their last value
//
// Both totals must fit a 10-bit counter (at most 1024). PIPE_DELAY is 0..3.
// ----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int unsigned H_DISPLAY   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_DISPLAY   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter logic        SYNC_ACTIVE = 1'b0,
    parameter int unsigned PIPE_DELAY  = 1
) (
    input  logic       clock,
    input  logic       rst,
    output logic [9:0] Pixel_column,
    output logic [9:0] Pixel_row,
    output logic       horiz_sync,
    output logic       vert_sync,
    output logic       video_on,
    output logic       end_of_line,
    output logic       end_of_frame
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // Decode boundaries, pre-sized to the counter width so every compare is
    // a plain unsigned 10-bit compare.
    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS_END    = 10'(V_DISPLAY);
    localparam logic [9:0] H_SYNC_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] V_SYNC_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [9:0] h_count_r;
    logic [9:0] v_count_r;
    logic       hsync_raw_s;
    logic       vsync_raw_s;
    logic       video_raw_s;
    logic       h_last_s;
    logic       v_last_s;

    assign Pixel_column = h_count_r;
    assign Pixel_row    = v_count_r;

    // Scan counters: column every clock, row on each column wrap.
    always_ff @(posedge clock) begin
        if (rst) begin
            h_count_r <= 10'd0;
            v_count_r <= 10'd0;
        end else if (h_last_s) begin
            h_count_r <= 10'd0;
            if (v_last_s) begin
                v_count_r <= 10'd0;
            end else begin
                v_count_r <= v_count_r + 10'd1;
            end
        end else begin
            h_count_r <= h_count_r + 10'd1;
        end
    end

    // Undelayed decodes of the current counter values.
    always_comb begin
        h_last_s    = 1'b0;
        v_last_s    = 1'b0;
        hsync_raw_s = ~SYNC_ACTIVE;
        vsync_raw_s = ~SYNC_ACTIVE;
        video_raw_s = 1'b0;

        h_last_s = (h_count_r == H_LAST);
        v_last_s = (v_count_r == V_LAST);

        if ((h_count_r >= H_SYNC_START) && (h_count_r < H_SYNC_END)) begin
            hsync_raw_s = SYNC_ACTIVE;
        end else begin
            hsync_raw_s = ~SYNC_ACTIVE;
        end

        if ((v_count_r >= V_SYNC_START) && (v_count_r < V_SYNC_END)) begin
            vsync_raw_s = SYNC_ACTIVE;
        end else begin
            vsync_raw_s = ~SYNC_ACTIVE;
        end

        if ((h_count_r < H_VIS_END) && (v_count_r < V_VIS_END)) begin
            video_raw_s = 1'b1;
        end else begin
            video_raw_s = 1'b0;
        end
    end

    assign end_of_line  = h_last_s;
    assign end_of_frame = h_last_s && v_last_s;

    generate
        if (PIPE_DELAY == 0) begin : g_no_pipe
            assign horiz_sync = hsync_raw_s;
            assign vert_sync  = vsync_raw_s;
            assign video_on   = video_raw_s;
        end else begin : g_pipe
            // Bit 0 is the newest stage; the top bit drives the output.
            logic [PIPE_DELAY-1:0] hs_pipe_r;
            logic [PIPE_DELAY-1:0] vs_pipe_r;
            logic [PIPE_DELAY-1:0] von_pipe_r;

            // Delay line for the strobes; reset flushes every stage to idle.
            always_ff @(posedge clock) begin
                if (rst) begin
                    hs_pipe_r  <= {PIPE_DELAY{~SYNC_ACTIVE}};
                    vs_pipe_r  <= {PIPE_DELAY{~SYNC_ACTIVE}};
                    von_pipe_r <= {PIPE_DELAY{1'b0}};
                end else begin
                    hs_pipe_r  <= PIPE_DELAY'({hs_pipe_r, hsync_raw_s});
                    vs_pipe_r  <= PIPE_DELAY'({vs_pipe_r, vsync_raw_s});
                    von_pipe_r <= PIPE_DELAY'({von_pipe_r, video_raw_s});
                end
            end

            assign horiz_sync = hs_pipe_r[PIPE_DELAY-1];
            assign vert_sync  = vs_pipe_r[PIPE_DELAY-1];
            assign video_on   = von_pipe_r[PIPE_DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// Testbench for vga_timing_gen. Three instances share clock and reset:
//   dut_d : default 640x480 timing, PIPE_DELAY=1, active-low syncs
//   dut_z : default timing, PIPE_DELAY=0, active-high syncs
//   dut_s : small 32x20 raster, PIPE_DELAY=2, active-low syncs, so whole
//           frames and vertical sync fit in a short run
// Expected values are hand-computed and queued with the cycle at which they
// apply; a negedge monitor compares every entry that falls due.
// Cycle numbering: cyc = k at the negedge after posedge k. rst is high for
// posedges 1..3, so t = cyc-3 is the count of clocks since release.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic clock = 1'b0;
    logic rst   = 1'b1;

    always #5 clock = ~clock;

    logic [9:0] d_col, d_row, z_col, z_row, s_col, s_row;
    logic d_hs, d_vs, d_von, d_eol, d_eof;
    logic z_hs, z_vs, z_von, z_eol, z_eof;
    logic s_hs, s_vs, s_von, s_eol, s_eof;

    vga_timing_gen dut_d (
        .clock(clock), .rst(rst),
        .Pixel_column(d_col), .Pixel_row(d_row),
        .horiz_sync(d_hs), .vert_sync(d_vs), .video_on(d_von),
        .end_of_line(d_eol), .end_of_frame(d_eof)
    );

    vga_timing_gen #(.SYNC_ACTIVE(1'b1), .PIPE_DELAY(0)) dut_z (
        .clock(clock), .rst(rst),
        .Pixel_column(z_col), .Pixel_row(z_row),
        .horiz_sync(z_hs), .vert_sync(z_vs), .video_on(z_von),
        .end_of_line(z_eol), .end_of_frame(z_eof)
    );

    vga_timing_gen #(
        .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
        .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(3), .V_BACK(3),
        .SYNC_ACTIVE(1'b0), .PIPE_DELAY(2)
    ) dut_s (
        .clock(clock), .rst(rst),
        .Pixel_column(s_col), .Pixel_row(s_row),
        .horiz_sync(s_hs), .vert_sync(s_vs), .video_on(s_von),
        .end_of_line(s_eol), .end_of_frame(s_eof)
    );

    // Probe selectors.
    localparam int D_COL = 0,  D_ROW = 1,  D_HS = 2,  D_VS = 3,  D_VON = 4;
    localparam int D_EOL = 5,  D_EOF = 6,  Z_HS = 7,  Z_VON = 8, S_COL = 9;
    localparam int S_ROW = 10, S_HS = 11, S_VS = 12, S_VON = 13, S_EOF = 14;
    localparam int A_D_HSLOW = 15, A_D_VON = 16, A_Z_HSHI = 17, A_Z_VON = 18;
    localparam int A_S_VON = 19, A_S_VSLOW = 20, A_S_HSLOW = 21, A_S_EOF = 22;

    typedef struct {
        int cyc;
        int sel;
        int exp;
    } exp_item_t;

    exp_item_t sb_q[$];
    exp_item_t keep_q[$];
    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;
    int acc [8];

    function automatic string probe_name(input int sel);
        case (sel)
            D_COL:     probe_name = "d_col";
            D_ROW:     probe_name = "d_row";
            D_HS:      probe_name = "d_hsync";
            D_VS:      probe_name = "d_vsync";
            D_VON:     probe_name = "d_video_on";
            D_EOL:     probe_name = "d_end_of_line";
            D_EOF:     probe_name = "d_end_of_frame";
            Z_HS:      probe_name = "z_hsync";
            Z_VON:     probe_name = "z_video_on";
            S_COL:     probe_name = "s_col";
            S_ROW:     probe_name = "s_row";
            S_HS:      probe_name = "s_hsync";
            S_VS:      probe_name = "s_vsync";
            S_VON:     probe_name = "s_video_on";
            S_EOF:     probe_name = "s_end_of_frame";
            A_D_HSLOW: probe_name = "d_hsync_low_count";
            A_D_VON:   probe_name = "d_video_on_count";
            A_Z_HSHI:  probe_name = "z_hsync_high_count";
            A_Z_VON:   probe_name = "z_video_on_count";
            A_S_VON:   probe_name = "s_video_on_count";
            A_S_VSLOW: probe_name = "s_vsync_low_count";
            A_S_HSLOW: probe_name = "s_hsync_low_count";
            A_S_EOF:   probe_name = "s_end_of_frame_count";
            default:   probe_name = "unknown";
        endcase
    endfunction

    function automatic int probe(input int sel);
        case (sel)
            D_COL:     probe = int'(d_col);
            D_ROW:     probe = int'(d_row);
            D_HS:      probe = int'(d_hs);
            D_VS:      probe = int'(d_vs);
            D_VON:     probe = int'(d_von);
            D_EOL:     probe = int'(d_eol);
            D_EOF:     probe = int'(d_eof);
            Z_HS:      probe = int'(z_hs);
            Z_VON:     probe = int'(z_von);
            S_COL:     probe = int'(s_col);
            S_ROW:     probe = int'(s_row);
            S_HS:      probe = int'(s_hs);
            S_VS:      probe = int'(s_vs);
            S_VON:     probe = int'(s_von);
            S_EOF:     probe = int'(s_eof);
            A_D_HSLOW: probe = acc[0];
            A_D_VON:   probe = acc[1];
            A_Z_HSHI:  probe = acc[2];
            A_Z_VON:   probe = acc[3];
            A_S_VON:   probe = acc[4];
            A_S_VSLOW: probe = acc[5];
            A_S_HSLOW: probe = acc[6];
            A_S_EOF:   probe = acc[7];
            default:   probe = -1;
        endcase
    endfunction

    task automatic expect_at(input int c, input int sel, input int exp);
        exp_item_t it;
        it.cyc = c;
        it.sel = sel;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    // Monitor: accumulate run-length counts, then check every entry due now.
    always @(negedge clock) begin
        cyc = cyc + 1;
        if (cyc >= 3 && cyc <= 1903) begin
            acc[0] = acc[0] + int'(d_hs == 1'b0);
            acc[1] = acc[1] + int'(d_von == 1'b1);
            acc[2] = acc[2] + int'(z_hs == 1'b1);
            acc[3] = acc[3] + int'(z_von == 1'b1);
            acc[4] = acc[4] + int'(s_von == 1'b1);
            acc[5] = acc[5] + int'(s_vs == 1'b0);
            acc[6] = acc[6] + int'(s_hs == 1'b0);
            acc[7] = acc[7] + int'(s_eof == 1'b1);
        end
        keep_q.delete();
        foreach (sb_q[i]) begin
            if (sb_q[i].cyc == cyc) begin
                n_checks = n_checks + 1;
                if (probe(sb_q[i].sel) != sb_q[i].exp) begin
                    n_fail = n_fail + 1;
                    $display("FAIL %s at cyc %0d: got %0d, expected %0d",
                             probe_name(sb_q[i].sel), cyc,
                             probe(sb_q[i].sel), sb_q[i].exp);
                end
            end else begin
                keep_q.push_back(sb_q[i]);
            end
        end
        sb_q = keep_q;
    end

    initial begin
        foreach (acc[i]) acc[i] = 0;

        // Reset state (posedge 1, reset held).
        expect_at(1, D_COL, 0);  expect_at(1, D_ROW, 0);  expect_at(1, D_HS, 1);
        expect_at(1, D_VS, 1);   expect_at(1, D_VON, 0);  expect_at(1, D_EOL, 0);
        expect_at(1, D_EOF, 0);  expect_at(1, Z_VON, 1);  expect_at(1, Z_HS, 0);
        expect_at(1, S_HS, 1);   expect_at(1, S_VON, 0);
        expect_at(3, D_COL, 0);
        // First clock after release, and two-stage pipeline fill.
        expect_at(4, D_COL, 1);  expect_at(4, D_VON, 1);  expect_at(4, S_VON, 0);
        expect_at(5, S_VON, 1);
        // Small raster hsync: raw low cols 20..25, seen 2 clocks later.
        expect_at(24, S_HS, 1);  expect_at(25, S_HS, 0);
        expect_at(30, S_HS, 0);  expect_at(31, S_HS, 1);
        // Small raster vsync: raw low rows 14..16 (t 448..543).
        expect_at(452, S_VS, 1); expect_at(453, S_VS, 0);
        expect_at(548, S_VS, 0); expect_at(549, S_VS, 1);
        // Small raster end of frame at t=639, (31,19).
        expect_at(641, S_EOF, 0);
        expect_at(642, S_EOF, 1); expect_at(642, S_COL, 31); expect_at(642, S_ROW, 19);
        expect_at(642, Z_VON, 1);
        expect_at(643, S_EOF, 0); expect_at(643, S_COL, 0);  expect_at(643, S_ROW, 0);
        expect_at(643, D_VON, 1); expect_at(643, Z_VON, 0);
        expect_at(644, D_VON, 0);
        expect_at(644, A_S_VON, 192);  expect_at(644, A_S_VSLOW, 96);
        expect_at(644, A_S_HSLOW, 120); expect_at(644, A_S_EOF, 1);
        // Default hsync edges: undelayed 656..751, delayed 657..752.
        expect_at(658, Z_HS, 0); expect_at(659, Z_HS, 1);
        expect_at(659, D_HS, 1); expect_at(660, D_HS, 0);
        expect_at(754, Z_HS, 1); expect_at(755, Z_HS, 0);
        expect_at(755, D_HS, 0); expect_at(756, D_HS, 1);
        // End of line 0.
        expect_at(801, D_EOL, 0);
        expect_at(802, D_EOL, 1); expect_at(802, D_COL, 799); expect_at(802, D_ROW, 0);
        expect_at(802, D_EOF, 0);
        expect_at(803, D_COL, 0); expect_at(803, D_ROW, 1); expect_at(803, D_EOL, 0);
        expect_at(1283, A_S_EOF, 2);
        // Counts over t = 0..1700.
        expect_at(1703, A_D_HSLOW, 192); expect_at(1703, A_D_VON, 1380);
        expect_at(1703, A_Z_HSHI, 192);  expect_at(1703, A_Z_VON, 1381);

        repeat (3) @(posedge clock);
        #1 rst = 1'b0;

        // Mid-frame reset: assert while dut_d shows row 2, column 300.
        repeat (1900) @(posedge clock);
        #1 rst = 1'b1;
        expect_at(1903, D_COL, 300); expect_at(1903, D_ROW, 2); expect_at(1903, D_VON, 1);
        expect_at(1904, D_COL, 0);  expect_at(1904, D_ROW, 0);  expect_at(1904, D_HS, 1);
        expect_at(1904, D_VS, 1);   expect_at(1904, D_VON, 0);  expect_at(1904, S_HS, 1);
        expect_at(1904, S_VS, 1);   expect_at(1904, S_VON, 0);  expect_at(1904, S_COL, 0);
        expect_at(1905, D_COL, 0);
        expect_at(1906, D_COL, 1);  expect_at(1906, D_ROW, 0);  expect_at(1906, D_VON, 1);
        expect_at(1906, S_VON, 0);
        expect_at(1907, S_VON, 1);
        expect_at(2704, D_COL, 799); expect_at(2704, D_EOL, 1);
        expect_at(2705, D_COL, 0);   expect_at(2705, D_ROW, 1);
        repeat (2) @(posedge clock);
        #1 rst = 1'b0;

        repeat (810) @(posedge clock);
        @(negedge clock);
        #1;
        n_checks = n_checks + 1;
        if (d_col != 10'd10) begin
            n_fail = n_fail + 1;
            $display("FAIL final d_col: got %0d, expected 10", d_col);
        end
        n_checks = n_checks + 1;
        if (d_row != 10'd1) begin
            n_fail = n_fail + 1;
            $display("FAIL final d_row: got %0d, expected 1", d_row);
        end
        n_checks = n_checks + 1;
        if (d_von != 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL final d_video_on: got %0d, expected 1", d_von);
        end
        n_checks = n_checks + 1;
        if (z_hs != 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL final z_hsync: got %0d, expected 0", z_hs);
        end
        foreach (sb_q[i]) begin
            n_checks = n_checks + 1;
            n_fail   = n_fail + 1;
            $display("FAIL %s never checked: due cyc %0d, expected %0d",
                     probe_name(sb_q[i].sel), sb_q[i].cyc, sb_q[i].exp);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
